// File: rtl/phs_avg_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | phs_avg_multi: NCH-channel complex weight, channel sum, boxcar average, saturation.   |
// | Define PHS_AVG_MULTI_OVF_EN for the sticky ovf port.            Revision: 1.0        |
// +--------------------------------------------------------------------------------------+
module phs_avg_multi #(
    parameter int NCH     = 2,
    parameter int DW      = 18,
    parameter int KW      = 18,
    parameter int OW      = 20,
    parameter int LOG_AVG = 4,
    parameter int SHIFT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq,
    input  logic [NCH*DW-1:0]    x,
    input  logic [NCH*KW-1:0]    k_re,
    input  logic [NCH*KW-1:0]    k_im,
    input  logic                 gate,
    input  logic                 clear,
    input  logic                 sel_imag,
    output logic signed [OW-1:0] z,
    output logic                 z_valid
`ifdef PHS_AVG_MULTI_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int PW = DW + KW;
    localparam int SW = PW + 1 + $clog2(NCH);
    localparam int AW = SW + LOG_AVG;
    localparam int CW = LOG_AVG + 1;
    localparam logic [CW-1:0]        LAST = CW'((1 << LOG_AVG) - 1);
    localparam logic signed [AW-1:0] ZMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] ZMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic                    ivalid;
    logic                    gate_l;
    logic [NCH*DW-1:0]       xi_l;
    logic [NCH*KW-1:0]       kr_l, ki_l;

    logic                    p_valid, p_sel;
    logic [NCH*DW-1:0]       p_xi, p_xq;
    logic [NCH*KW-1:0]       p_kr, p_ki;

    logic [NCH*PW-1:0]       m_rr, m_iq, m_rq, m_ii;
    logic [NCH*PW-1:0]       s1_rr, s1_iq, s1_rq, s1_ii;
    logic                    s1_valid, s1_sel;

    logic signed [SW-1:0]    sum_re, sum_im;
    logic signed [SW-1:0]    s2_re, s2_im, part;
    logic                    s2_valid, s2_sel;

    logic signed [AW-1:0]    acc, acc_base, acc_shr;
    logic [CW-1:0]           cnt;
    logic                    done;
    logic signed [OW-1:0]    z_sat;
`ifdef PHS_AVG_MULTI_OVF_EN
    logic                    z_hit;
`endif

    // I-latch: the pair always uses the coefficients captured with its I sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ivalid <= 1'b0;
        end else begin
            ivalid <= ~iq;
        end
    end

    always_ff @(posedge clk) begin
        if (!iq) begin
            xi_l   <= x;
            kr_l   <= k_re;
            ki_l   <= k_im;
            gate_l <= gate;
        end
    end

    // Gated-off pairs are dropped here so they neither accumulate nor count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= iq & ivalid & gate_l & ~clear;
        end
    end

    always_ff @(posedge clk) begin
        if (iq && ivalid) begin
            p_xi  <= xi_l;
            p_xq  <= x;
            p_kr  <= kr_l;
            p_ki  <= ki_l;
            p_sel <= sel_imag;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [DW-1:0] xi_c, xq_c;
        logic signed [KW-1:0] kr_c, ki_c;

        assign xi_c = p_xi[c*DW +: DW];
        assign xq_c = p_xq[c*DW +: DW];
        assign kr_c = p_kr[c*KW +: KW];
        assign ki_c = p_ki[c*KW +: KW];

        assign m_rr[c*PW +: PW] = PW'(kr_c) * PW'(xi_c);
        assign m_iq[c*PW +: PW] = PW'(ki_c) * PW'(xq_c);
        assign m_rq[c*PW +: PW] = PW'(kr_c) * PW'(xq_c);
        assign m_ii[c*PW +: PW] = PW'(ki_c) * PW'(xi_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= p_valid & ~clear;
            s2_valid <= s1_valid & ~clear;
        end
    end

    always_ff @(posedge clk) begin
        if (p_valid) begin
            s1_rr  <= m_rr;
            s1_iq  <= m_iq;
            s1_rq  <= m_rq;
            s1_ii  <= m_ii;
            s1_sel <= p_sel;
        end
        if (s1_valid) begin
            s2_re  <= sum_re;
            s2_im  <= sum_im;
            s2_sel <= s1_sel;
        end
    end

    always_comb begin
        sum_re = '0;
        sum_im = '0;
        for (int c = 0; c < NCH; c++) begin
            sum_re = sum_re + SW'($signed(s1_rr[c*PW +: PW])) - SW'($signed(s1_iq[c*PW +: PW]));
            sum_im = sum_im + SW'($signed(s1_rq[c*PW +: PW])) + SW'($signed(s1_ii[c*PW +: PW]));
        end
    end

    assign part     = s2_sel ? s2_im : s2_re;
    // A finished window is held one cycle for the output, then restarts from zero
    assign acc_base = done ? '0 : acc;
    assign acc_shr  = acc >>> SHIFT;

    always_comb begin
        z_sat = acc_shr[OW-1:0];
`ifdef PHS_AVG_MULTI_OVF_EN
        z_hit = 1'b0;
`endif
        if (acc_shr > ZMAX) begin
            z_sat = ZMAX[OW-1:0];
`ifdef PHS_AVG_MULTI_OVF_EN
            z_hit = 1'b1;
`endif
        end else if (acc_shr < ZMIN) begin
            z_sat = ZMIN[OW-1:0];
`ifdef PHS_AVG_MULTI_OVF_EN
            z_hit = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            z       <= '0;
            z_valid <= 1'b0;
`ifdef PHS_AVG_MULTI_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (clear) begin
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            z_valid <= 1'b0;
`ifdef PHS_AVG_MULTI_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            z_valid <= done;
            if (done) begin
                z <= z_sat;
`ifdef PHS_AVG_MULTI_OVF_EN
                if (z_hit) begin
                    ovf <= 1'b1;
                end
`endif
            end
            if (s2_valid) begin
                acc <= acc_base + AW'(part);
                if (cnt == LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt  <= cnt + CW'(1);
                    done <= 1'b0;
                end
            end else begin
                acc  <= acc_base;
                done <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phs_avg_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_phs_avg_multi: scoreboard bench, pair-level reference model, two SHIFT settings.  |
// | Revision: 1.0                                                                        |
// +--------------------------------------------------------------------------------------+
module tb_phs_avg_multi;

    localparam int NCH = 2, DW = 18, KW = 18, OW = 20, LOG_AVG = 4;
    localparam int SHA = 16, SHB = 0;
    localparam longint ZHI = (longint'(1) << (OW - 1)) - 1;
    localparam longint ZLO = -(longint'(1) << (OW - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, iq, gate, clear, sel_imag;
    logic [NCH*DW-1:0] x;
    logic [NCH*KW-1:0] k_re, k_im;
    logic signed [OW-1:0] z_a, z_b;
    logic zv_a, zv_b;
`ifdef PHS_AVG_MULTI_OVF_EN
    logic ovf_a, ovf_b;
`endif

    phs_avg_multi #(.NCH(NCH), .DW(DW), .KW(KW), .OW(OW), .LOG_AVG(LOG_AVG), .SHIFT(SHA)) dut_a (
        .clk(clk), .rst_n(rst_n), .iq(iq), .x(x), .k_re(k_re), .k_im(k_im), .gate(gate),
        .clear(clear), .sel_imag(sel_imag), .z(z_a), .z_valid(zv_a)
`ifdef PHS_AVG_MULTI_OVF_EN
        , .ovf(ovf_a)
`endif
    );

    phs_avg_multi #(.NCH(NCH), .DW(DW), .KW(KW), .OW(OW), .LOG_AVG(LOG_AVG), .SHIFT(SHB)) dut_b (
        .clk(clk), .rst_n(rst_n), .iq(iq), .x(x), .k_re(k_re), .k_im(k_im), .gate(gate),
        .clear(clear), .sel_imag(sel_imag), .z(z_b), .z_valid(zv_b)
`ifdef PHS_AVG_MULTI_OVF_EN
        , .ovf(ovf_b)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     cyc;
        longint za;
        longint zb;
        bit     sa;
        bit     sb;
    } exp_t;
    exp_t q[$];

    int n_chk = 0, n_err = 0;
    int clr_cyc = -1, rst_cyc = -1, clr_at = -1;

    int v_xi[NCH], v_xq[NCH], v_kr[NCH], v_ki[NCH];
    bit scramble = 1'b0;

    longint m_xi[NCH], m_kr[NCH], m_ki[NCH];
    bit     m_iv = 1'b0, m_g = 1'b0;
    longint m_sum = 0;
    int     m_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail(input string nm, input longint info);
        n_chk++;
        n_err++;
        $display("FAIL %s: value %0d (cycle %0d)", nm, info, cyc);
    endtask

    function automatic longint sat(input longint v);
        if (v > ZHI) return ZHI;
        if (v < ZLO) return ZLO;
        return v;
    endfunction

    function automatic int rs(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic drop(input int e);
        while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
    endtask

    // Reference: per-pair complex arithmetic on edge numbers; a strobe is due 4 edges after the last Q
    task automatic model_edge(input int e);
        longint re, im, xq, sa, sb;
        exp_t n;
        if (!rst_n) begin
            m_iv = 1'b0; m_sum = 0; m_cnt = 0; rst_cyc = e;
            drop(e);
            return;
        end
        if (iq && m_iv && m_g) begin
            re = 0; im = 0;
            for (int c = 0; c < NCH; c++) begin
                xq = longint'($signed(x[c*DW +: DW]));
                re += m_kr[c] * m_xi[c] - m_ki[c] * xq;
                im += m_kr[c] * xq + m_ki[c] * m_xi[c];
            end
            m_sum += sel_imag ? im : re;
            m_cnt++;
            if (m_cnt == (1 << LOG_AVG)) begin
                sa = m_sum >>> SHA;
                sb = m_sum >>> SHB;
                n.cyc = e + 4; n.za = sat(sa); n.zb = sat(sb);
                n.sa = (n.za != sa); n.sb = (n.zb != sb);
                q.push_back(n);
                m_sum = 0; m_cnt = 0;
            end
        end
        if (!iq) begin
            m_iv = 1'b1; m_g = gate;
            for (int c = 0; c < NCH; c++) begin
                m_xi[c] = longint'($signed(x[c*DW +: DW]));
                m_kr[c] = longint'($signed(k_re[c*KW +: KW]));
                m_ki[c] = longint'($signed(k_im[c*KW +: KW]));
            end
        end else begin
            m_iv = 1'b0;
        end
        if (clear) begin
            m_sum = 0; m_cnt = 0; clr_cyc = e;
            drop(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(cyc);
        @(negedge clk);
    endtask

    task automatic drive_pair(input bit g, input bit s);
        iq = 1'b0; gate = g; clear = (cyc + 1 == clr_at); sel_imag = 1'($urandom_range(0, 1));
        for (int c = 0; c < NCH; c++) begin
            x[c*DW +: DW]    = DW'(v_xi[c]);
            k_re[c*KW +: KW] = KW'(v_kr[c]);
            k_im[c*KW +: KW] = KW'(v_ki[c]);
        end
        tick();
        iq = 1'b1; gate = 1'($urandom_range(0, 1)); clear = (cyc + 1 == clr_at); sel_imag = s;
        for (int c = 0; c < NCH; c++) begin
            x[c*DW +: DW] = DW'(v_xq[c]);
            if (scramble) begin
                k_re[c*KW +: KW] = KW'(rs(KW));
                k_im[c*KW +: KW] = KW'(rs(KW));
            end
        end
        tick();
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        iq = 1'b1; clear = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_tick();
        iq = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load_nominal(input int sgn);
        v_kr = '{700, 600};
        v_ki = '{100, 200};
        v_xi = '{2000 * sgn, 1000 * sgn};
        v_xq = '{600 * sgn, 500 * sgn};
    endtask

    // Monitor: pops the scoreboard whenever either DUT strobes or a strobe is overdue
    initial begin : mon
        exp_t e;
        bit st_a = 1'b0, st_b = 1'b0;
        longint zl_a = 0, zl_b = 0;
        forever begin
            @(negedge clk);
            if (rst_cyc == cyc) begin
                zl_a = 0; zl_b = 0;
            end
            if (rst_cyc == cyc || clr_cyc == cyc) begin
                st_a = 1'b0; st_b = 1'b0;
                chk("restart_zvalid", zv_a | zv_b, 0);
                chk("restart_z_a", z_a, zl_a);
                chk("restart_z_b", z_b, zl_b);
`ifdef PHS_AVG_MULTI_OVF_EN
                chk("restart_ovf", ovf_a | ovf_b, 0);
`endif
            end else if (zv_a || zv_b) begin
                if (q.size() == 0) begin
                    fail("spurious_strobe", z_a);
                end else begin
                    e = q.pop_front();
                    chk("strobe_both", zv_a & zv_b, 1);
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("z_a", z_a, e.za);
                    chk("z_b", z_b, e.zb);
                    zl_a = e.za; zl_b = e.zb;
                    st_a |= e.sa; st_b |= e.sb;
`ifdef PHS_AVG_MULTI_OVF_EN
                    chk("ovf_a", ovf_a, st_a);
                    chk("ovf_b", ovf_b, st_b);
`endif
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                fail("missing_strobe", e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; iq = 1'b1; gate = 1'b1; clear = 1'b0; sel_imag = 1'b1;
        x = '0; k_re = '0; k_im = '0;
        tick(); tick(); tick();
        chk("reset_z", z_a, 0);
        chk("reset_zvalid", zv_a, 0);
        rst_n = 1'b1;

        load_nominal(1);
        for (int p = 0; p < 36; p++) drive_pair(1'b1, 1'b1);
        idle(6);
        chk("nominal_imag", z_a, 273);
        chk("sat_pos", z_b, 524287);
`ifdef PHS_AVG_MULTI_OVF_EN
        chk("ovf_sticky", ovf_b, 1);
`endif

        clr_tick();
        for (int p = 0; p < 32; p++) drive_pair(1'b1, 1'b0);
        idle(6);
        chk("nominal_real", z_a, 449);

        clr_tick();
        load_nominal(-1);
        for (int p = 0; p < 32; p++) drive_pair(1'b1, 1'b1);
        idle(6);
        chk("negated_imag", z_a, -274);
        chk("sat_neg", z_b, -524288);

        clr_tick();
        load_nominal(1);
        for (int p = 0; p < 64; p++) drive_pair(p % 2 == 0, 1'b1);
        idle(6);
        chk("gated_imag", z_a, 273);

        clr_tick();
        for (int p = 0; p < 32; p++) begin
            if (p == 5) idle(1);
            if (p == 9) begin
                iq = 1'b0; gate = 1'b1;
                x = {DW'(77777), DW'(-55555)};
                tick();
            end
            drive_pair(1'b1, 1'b1);
        end
        idle(6);
        chk("framing_imag", z_a, 273);

        // Clear lands exactly on the first completion edge of this window
        clr_tick();
        clr_at = -1;
        for (int p = 0; p < 40; p++) begin
            if (clr_at < 0 && q.size() > 0) clr_at = q[0].cyc;
            drive_pair(1'b1, 1'b1);
        end
        idle(6);
        chk("after_clear_imag", z_a, 273);

        clr_tick();
        for (int p = 0; p < 8; p++) drive_pair(1'b1, 1'b1);
        rst_n = 1'b0;
        idle(2);
        chk("midreset_z", z_a, 0);
        rst_n = 1'b1;
        for (int p = 0; p < 20; p++) drive_pair(1'b1, 1'b1);
        idle(6);
        chk("after_reset_imag", z_a, 273);

        scramble = 1'b1;
        for (int p = 0; p < 300; p++) begin
            int r;
            for (int c = 0; c < NCH; c++) begin
                v_xi[c] = rs(DW); v_xq[c] = rs(DW);
                v_kr[c] = rs(KW); v_ki[c] = rs(KW);
            end
            r = int'($urandom_range(0, 19));
            if (r == 0) idle(1);
            if (r == 1) begin
                iq = 1'b0; gate = 1'($urandom_range(0, 1));
                x = {DW'(rs(DW)), DW'(rs(DW))};
                k_re = {KW'(rs(KW)), KW'(rs(KW))};
                k_im = {KW'(rs(KW)), KW'(rs(KW))};
                tick();
            end
            if (r == 2 && clr_at <= cyc) clr_at = cyc + int'($urandom_range(2, 40));
            if (p == 150) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
            drive_pair($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
        end
        idle(10);
        if (q.size() != 0) fail("undelivered_strobes", q.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
